// File: rtl/register_file.sv
// MIPS register file: 32 x WIDTH storage, two combinational read ports, one write port.
// Ports: clk, reset (async, active-high), regwr/write_addr/write_data (write port),
//   read_addr1/read_addr2 -> read_data1/read_data2 (combinational reads).
//   $0 reads as zero and ignores writes. REGFILE_BYPASS_EN adds same-cycle write forwarding.
module register_file #(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 regwr,
  input  logic [ADDR_BITS-1:0] write_addr,
  input  logic [WIDTH-1:0]     write_data,
  input  logic [ADDR_BITS-1:0] read_addr1,
  input  logic [ADDR_BITS-1:0] read_addr2,
  output logic [WIDTH-1:0]     read_data1,
  output logic [WIDTH-1:0]     read_data2
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic             wr_en;

  assign wr_en = regwr && (write_addr != '0);

  // Entry 0 never loads, so it stays at its reset value of zero.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      regs_d[i] = regs_q[i];
    end
    for (int i = 1; i < DEPTH; i++) begin
      if (wr_en && (write_addr == ADDR_BITS'(i))) begin
        regs_d[i] = write_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  logic [WIDTH-1:0] stored1;
  logic [WIDTH-1:0] stored2;

  always_comb begin
    stored1 = '0;
    stored2 = '0;
    if (read_addr1 != '0) stored1 = regs_q[read_addr1];
    if (read_addr2 != '0) stored2 = regs_q[read_addr2];
  end

`ifdef REGFILE_BYPASS_EN
  // Forwarding is suppressed under reset so both ports read zero there.
  logic byp1;
  logic byp2;

  always_comb begin
    byp1 = !reset && wr_en && (read_addr1 == write_addr);
    byp2 = !reset && wr_en && (read_addr2 == write_addr);
    read_data1 = byp1 ? write_data : stored1;
    read_data2 = byp2 ? write_data : stored2;
  end
`else
  always_comb begin
    read_data1 = stored1;
    read_data2 = stored2;
  end
`endif

`ifndef SYNTHESIS
  // Unknown write controls: report; the X-valued compare keeps storage unchanged.
  always_ff @(posedge clk) begin
    if (!reset && ($isunknown(regwr) ||
        ((regwr !== 1'b0) && $isunknown(write_addr)))) begin
      $display("ERROR: register_file regwr/write_addr unknown at %0t", $time);
    end
  end
`endif

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: stimulus queues expected read values,
// a negedge monitor pops and compares them against the read ports.
module tb_register_file;

  logic        clk;
  logic        reset;
  logic        regwr;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic [4:0]  read_addr1;
  logic [4:0]  read_addr2;
  logic [31:0] read_data1;
  logic [31:0] read_data2;

  register_file #(.WIDTH(32), .ADDR_BITS(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .regwr      (regwr),
    .write_addr (write_addr),
    .write_data (write_data),
    .read_addr1 (read_addr1),
    .read_addr2 (read_addr2),
    .read_data1 (read_data1),
    .read_data2 (read_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        port;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  int   total  = 0;
  int   passed = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // Monitor: read ports are combinational, sampled mid-cycle.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e   = q.pop_front();
      act = e.port ? read_data2 : read_data1;
      total++;
      if (act === e.exp) passed++;
      else $display("FAIL %s port%0d got %h expected %h",
                    e.name, e.port ? 2 : 1, act, e.exp);
    end
  end

  task automatic drive(input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] a1,
                       input logic [4:0] a2);
    @(posedge clk);
    #1;
    regwr      = we;
    write_addr = wa;
    write_data = wd;
    read_addr1 = a1;
    read_addr2 = a2;
  endtask

  task automatic expect1(input string n, input logic [31:0] v);
    exp_t e;
    e.name = n; e.port = 1'b0; e.exp = v;
    q.push_back(e);
  endtask

  task automatic expect2(input string n, input logic [31:0] v);
    exp_t e;
    e.name = n; e.port = 1'b1; e.exp = v;
    q.push_back(e);
  endtask

  initial begin
    reset      = 1'b1;
    regwr      = 1'b0;
    write_addr = '0;
    write_data = '0;
    read_addr1 = '0;
    read_addr2 = '0;

    // During reset, even with a write presented.
    drive(1'b1, 5'd3, 32'h5555_AAAA, 5'd3, 5'd4);
    expect1("in_reset_rd1", 32'h0);
    expect2("in_reset_rd2", 32'h0);
    drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd0);
    expect1("in_reset_after_blocked_wr", 32'h0);

    // 1: all entries read zero after reset.
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
      expect1("post_reset_rd1", 32'h0);
      expect2("post_reset_rd2", 32'h0);
    end

    // 2: write r5.
    drive(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd6);
    expect1("r5_pre_edge", BYP ? 32'hDEAD_BEEF : 32'h0);
    expect2("r6_pre_edge", 32'h0);
    drive(1'b0, 5'd5, 32'h0, 5'd5, 5'd6);
    expect1("r5_written", 32'hDEAD_BEEF);
    expect2("r6_untouched", 32'h0);
    for (int i = 1; i < 32; i += 6) begin
      drive(1'b0, 5'd0, 32'h0, 5'd5, 5'(i));
      expect1("r5_hold", 32'hDEAD_BEEF);
      expect2("others_zero", 32'h0);
    end

    // 3: write to $0 dropped, also not forwarded.
    drive(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
    expect1("r0_wr_pre", 32'h0);
    expect2("r0_wr_pre", 32'h0);
    drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
    expect1("r5_after_r0_wr", 32'hDEAD_BEEF);
    expect2("r0_after_wr", 32'h0);

    // 4: regwr=0 leaves r7 alone.
    drive(1'b1, 5'd7, 32'h0000_0011, 5'd0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 5'd7, 32'h1234_5678, 5'd7, 5'd7);
      expect1("r7_no_we", 32'h0000_0011);
      expect2("r7_no_we", 32'h0000_0011);
    end
    drive(1'b0, 5'd0, 32'h0, 5'd7, 5'd5);
    expect1("r7_final", 32'h0000_0011);
    expect2("r5_still", 32'hDEAD_BEEF);

    // 5: read-during-write on r9.
    drive(1'b1, 5'd9, 32'h0000_000A, 5'd0, 5'd0);
    drive(1'b1, 5'd9, 32'h0000_000B, 5'd9, 5'd7);
    expect1("r9_rdw_pre", BYP ? 32'h0000_000B : 32'h0000_000A);
    expect2("r7_during_r9_wr", 32'h0000_0011);
    drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
    expect1("r9_rdw_post", 32'h0000_000B);
    expect2("r9_rdw_post", 32'h0000_000B);
    drive(1'b1, 5'd9, 32'h0000_000C, 5'd7, 5'd9);
    expect1("r7_port1_no_byp", 32'h0000_0011);
    expect2("r9_rdw_port2", BYP ? 32'h0000_000C : 32'h0000_000B);

    // 6: reset mid-operation, pending write lost.
    drive(1'b1, 5'd31, 32'h0040_0020, 5'd0, 5'd0);
    drive(1'b0, 5'd0, 32'h0, 5'd31, 5'd9);
    expect1("r31_written", 32'h0040_0020);
    expect2("r9_c", 32'h0000_000C);
    drive(1'b1, 5'd31, 32'h0000_CAFE, 5'd31, 5'd5);
    reset = 1'b1;
    expect1("r31_async_clr", 32'h0);
    expect2("r5_async_clr", 32'h0);
    drive(1'b0, 5'd0, 32'h0, 5'd31, 5'd9);
    reset = 1'b0;
    expect1("r31_pending_lost", 32'h0);
    expect2("r9_cleared", 32'h0);
    drive(1'b1, 5'd31, 32'h1234_0000, 5'd31, 5'd0);
    expect1("r31_rewrite_pre", BYP ? 32'h1234_0000 : 32'h0);
    drive(1'b0, 5'd0, 32'h0, 5'd31, 5'd5);
    expect1("r31_rewrite", 32'h1234_0000);
    expect2("r5_zero", 32'h0);

    // Drain: every queued expectation must have been consumed.
    @(posedge clk);
    @(posedge clk);
    total++;
    if (q.size() == 0) passed++;
    else $display("FAIL scoreboard_drain left %0d expected 0", q.size());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
